// File: rtl/neck_guard_ctrl.sv
// IGBT gate controller for the welder power switch: neck start/end judging from
// derivative samples, PWM drive test, bypass-on and forced-off modes.
module neck_guard_ctrl #(
  parameter int DW            = 13,
  parameter int D1_TH         = 30,
  parameter int D2_START_TH   = 30,
  parameter int D2_END_TH     = -20,
  parameter int D3_BAND       = 40,
  parameter int CONFIRM       = 2,
  parameter int TIMEOUT       = 5000,
  parameter int HOLDOFF       = 500,
  parameter int PWM_PERIOD    = 2000,
  parameter int PWM_OFF_START = 1800,
  parameter int CW            = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_judge,
  input  logic [1:0]           mode,
  input  logic signed [DW-1:0] first_order_data,
  input  logic signed [DW-1:0] second_order_data,
  input  logic signed [DW-1:0] third_order_data,
  output logic                 power_switch,
  output logic                 neck_active,
  output logic                 timeout_pulse,
  output logic [15:0]          neck_count
);

  // state   | meaning
  // ST_ON   | power on, counting start-qualified cycles
  // ST_OFF  | neck in progress, power off, timeout timer running
  // ST_HOLD | power on, start detection masked for HOLDOFF cycles
  typedef enum logic [1:0] {ST_ON, ST_OFF, ST_HOLD} state_e;

  localparam logic signed [DW-1:0] D1_TH_S  = DW'(D1_TH);
  localparam logic signed [DW-1:0] D2_ST_S  = DW'(D2_START_TH);
  localparam logic signed [DW-1:0] D2_END_S = DW'(D2_END_TH);
  localparam logic signed [DW-1:0] D3_HI_S  = DW'(D3_BAND);
  localparam logic signed [DW-1:0] D3_LO_S  = DW'(-D3_BAND);

  state_e          state_q, state_d;
  logic [CW-1:0]   run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   pwm_q, pwm_d;
  logic            ps_q, ps_d;
  logic            na_q, na_d;
  logic            tp_q, tp_d;
  logic [15:0]     neck_count_q;
  logic            neck_inc;
  logic            d1_ok, d3_ok, s_qual, e_qual;

  assign d1_ok  = first_order_data > D1_TH_S;
  assign d3_ok  = (third_order_data > D3_LO_S) && (third_order_data < D3_HI_S);
  assign s_qual = en_judge && d1_ok && d3_ok && (second_order_data > D2_ST_S);
  assign e_qual = en_judge && d1_ok && d3_ok && (second_order_data < D2_END_S);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    cnt_d    = cnt_q;
    pwm_d    = '0;
    ps_d     = 1'b1;
    na_d     = 1'b0;
    tp_d     = 1'b0;
    neck_inc = 1'b0;
    unique case (mode)
      2'd1: begin
        unique case (state_q)
          ST_ON: begin
            if (!s_qual) begin
              run_d = '0;
            end else if (run_q == CW'(CONFIRM - 1)) begin
              state_d  = ST_OFF;
              run_d    = '0;
              cnt_d    = '0;
              neck_inc = 1'b1;
            end else begin
              run_d = run_q + 1'b1;
            end
          end
          ST_OFF: begin
            if (e_qual || (cnt_q == CW'(TIMEOUT - 1))) begin
              // A simultaneous end qualifier wins: that is a normal end.
              tp_d    = !e_qual;
              cnt_d   = '0;
              state_d = (HOLDOFF == 0) ? ST_ON : ST_HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_HOLD: begin
            run_d = '0;
            if (cnt_q == CW'(HOLDOFF - 1)) begin
              state_d = ST_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = ST_ON;
        endcase
        ps_d = (state_d != ST_OFF);
        na_d = (state_d == ST_OFF);
      end
      2'd2: begin
        state_d = ST_ON;
        run_d   = '0;
        cnt_d   = '0;
        ps_d    = (pwm_q < CW'(PWM_OFF_START));
        pwm_d   = (pwm_q == CW'(PWM_PERIOD - 1)) ? '0 : pwm_q + 1'b1;
      end
      2'd3: begin
        state_d = ST_ON;
        run_d   = '0;
        cnt_d   = '0;
        ps_d    = 1'b0;
      end
      default: begin
        state_d = ST_ON;
        run_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ON;
      run_q        <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      ps_q         <= 1'b1;
      na_q         <= 1'b0;
      tp_q         <= 1'b0;
      neck_count_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
      na_q    <= na_d;
      tp_q    <= tp_d;
      if (neck_inc && (neck_count_q != 16'hFFFF)) begin
        neck_count_q <= neck_count_q + 16'd1;
      end
    end
  end

  assign power_switch  = ps_q;
  assign neck_active   = na_q;
  assign timeout_pulse = tp_q;
  assign neck_count    = neck_count_q;

endmodule

// File: doc/neck_guard_ctrl.md
Name: neck_guard_ctrl

Overview:
- Parametrised successor to the single-channel neck judge/PWM-test block; drives the welder power-switch IGBT gate.
- Detects neck start/end from signed 1st/2nd/3rd-order derivative samples with multi-cycle confirmation, off-time timeout and post-event hold-off.
- Provides selectable modes: bypass-on, neck judge, PWM drive test, forced-off.
- Sits between the differentiator pipeline and the IGBT driver pin.

Parameters:
- DW, 13: width of signed derivative inputs.
- D1_TH, 30: d1 threshold, start and end (signed, strict >).
- D2_START_TH, 30: d2 start threshold (strict >).
- D2_END_TH, -20: d2 end threshold (strict <).
- D3_BAND, 40: d3 window half-width; requires -D3_BAND < d3 < D3_BAND.
- CONFIRM, 2: consecutive start-qualified cycles required (>=1).
- TIMEOUT, 5000: maximum power-off cycles per neck (>=1).
- HOLDOFF, 500: cycles start detection is ignored after re-enable (0 allowed).
- PWM_PERIOD, 2000: test-mode period in cycles (>=2).
- PWM_OFF_START, 1800: test-mode count at which the switch turns off (0 < PWM_OFF_START < PWM_PERIOD).
- CW, 16: internal counter width; must hold max(TIMEOUT, HOLDOFF, PWM_PERIOD).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en_judge  in  1  derivative samples valid this cycle
- mode  in  2  0 bypass-on, 1 judge, 2 PWM test, 3 forced-off
- first_order_data  in  DW  signed d1
- second_order_data  in  DW  signed d2
- third_order_data  in  DW  signed d3
- power_switch  out  1  1 = welder power on
- neck_active  out  1  1 while FSM is in OFF
- timeout_pulse  out  1  one-cycle pulse when an OFF period ends by timeout
- neck_count  out  16  saturating count of OFF entries

Behaviour:
- Clocking and reset: single clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset values (`rst` sampled high on a clk edge):
  - power_switch=1, neck_active=0, timeout_pulse=0, neck_count=0.
  - FSM=ON; all counters 0.
  - Reset mid-neck reopens power on the same edge.
- Qualifiers (combinational, signed compares at DW bits; thresholds sign-extended to DW):
  - S = en_judge & d1>D1_TH & d2>D2_START_TH & d3>-D3_BAND & d3<D3_BAND.
  - E = en_judge & d1>D1_TH & d2<D2_END_TH & d3>-D3_BAND & d3<D3_BAND.
- Judge FSM (mode==1): all outputs registered.
  - ON: power_switch=1.
    - run counter increments while S, clears when !S.
    - When S and run==CONFIRM-1: go to OFF, clear run, neck_count+=1 (saturating at 16'hFFFF).
    - With CONFIRM=1, S at edge k drops power_switch after edge k.
  - OFF: power_switch=0, neck_active=1; timer increments from 0 each cycle.
    - If E: go to HOLDOFF (normal end).
    - Else if timer==TIMEOUT-1: go to HOLDOFF and assert timeout_pulse for exactly one cycle.
    - Timeout therefore yields exactly TIMEOUT cycles of power_switch=0.
    - E and timeout on the same cycle: treated as normal end, no timeout_pulse.
    - E on the first OFF cycle is honoured (minimum off time 1 cycle).
    - en_judge low in OFF: only timeout can exit.
  - HOLDOFF: power_switch=1, S ignored, run held 0.
    - Go to ON after HOLDOFF cycles.
    - HOLDOFF=0: OFF exits directly to ON.
- Mode handling:
  - Any mode != 1 forces FSM to ON and clears run/timer/holdoff counters each cycle. neck_count is retained.
  - Mode 0: power_switch=1.
  - Mode 3: power_switch=0. neck_active stays 0.
  - Mode 2 (PWM test):
    - pwm_cnt runs 0..PWM_PERIOD-1 and wraps to 0.
    - Registered output: power_switch=1 when pwm_cnt < PWM_OFF_START, else 0.
    - Duty on = PWM_OFF_START/PWM_PERIOD.
    - pwm_cnt is cleared whenever mode != 2, so entering mode 2 starts a fresh period. The first cycle in mode 2 registers power_switch=1.
  - Mode change takes effect on the output one cycle after the edge sampling the new mode.
  - Leaving mode 1 mid-OFF restores power with no timeout_pulse.

Test Plan:
- Reset and bypass: assert rst 2 cycles, mode=1, idle inputs -> power_switch=1, neck_count=0, neck_active=0; rst during OFF -> power_switch=1 next edge.
- Normal neck (CONFIRM=2, HOLDOFF=500):
  - Drive d1=50, d2=40, d3=0 with en_judge for 2 cycles -> power_switch=0 after the 2nd edge, neck_count=1.
  - 100 cycles later drive d1=50, d2=-30, d3=10 -> power_switch=1 next edge, no timeout_pulse.
  - S held for the next 500 cycles -> stays 1; re-entry allowed after.
- Confirmation reject: S for 1 cycle then d2=0 -> power_switch stays 1, neck_count unchanged; d3=40 with d1=50, d2=40 (boundary) -> not qualified.
- Timeout (TIMEOUT=5000): enter OFF, never assert E -> power_switch low for exactly 5000 cycles, one-cycle timeout_pulse coincident with return to 1.
- PWM test: mode=2 for 6000 cycles -> repeating pattern of 1800 cycles high then 200 cycles low; switching to mode 3 -> power_switch=0 next cycle; back to mode 2 -> period restarts high.
- Mode abort and saturation: mode 1→0 while OFF -> power_switch=1, no pulse; preload or run 65536 necks -> neck_count holds 16'hFFFF.
